// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: takes a 16-bit little-endian word count, then
// little-endian 32-bit words, and writes them out. The core is held in reset until the load ends.
module imem_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        we,
  output logic [15:0] waddr,
  output logic [31:0] wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  state_t      state_q, state_d;
  logic [7:0]  cnt_lo_q, cnt_lo_d;
  logic [15:0] words_left_q, words_left_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [15:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic        xfer;
  logic [15:0] full_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_lo_q     <= '0;
      words_left_q <= '0;
      byte_idx_q   <= '0;
      waddr_q      <= BASE_ADDR;
      wdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_lo_q     <= cnt_lo_d;
      words_left_q <= words_left_d;
      byte_idx_q   <= byte_idx_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
    end
  end

  // byte_ready depends only on registered state, so xfer has no path back to outputs.
  assign byte_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA);
  assign xfer       = byte_valid && byte_ready;
  assign full_cnt   = {byte_data, cnt_lo_q};

  always_comb begin
    state_d      = state_q;
    cnt_lo_d     = cnt_lo_q;
    words_left_d = words_left_q;
    byte_idx_d   = byte_idx_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LEN_LO;
          waddr_d = BASE_ADDR;
          err_d   = 1'b0;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          cnt_lo_d = byte_data;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          if (full_cnt == '0) begin
            state_d = S_DONE;
          end else if ({1'b0, full_cnt} > MAX_W) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d      = S_DATA;
            words_left_d = full_cnt;
            byte_idx_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          wdata_d[8*byte_idx_q +: 8] = byte_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        waddr_d      = waddr_q + 16'd4;
        words_left_d = words_left_q - 16'd1;
        state_d      = (words_left_q == 16'd1) ? S_DONE : S_DATA;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign we       = (state_q == S_WRITE);
  assign done     = (state_q == S_DONE);
  assign cpu_hold = !((state_q == S_DONE) && !err_q);
  assign err      = err_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: unit 0 at base 0x0000 with a 4-word limit,
// unit 1 at base 0xFFFC to exercise address wrap and reload.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  start_v, bv_v;
  logic [7:0]  bd;
  logic [1:0]  rdy_w, we_w, hold_w, done_w, err_w;
  logic [15:0] waddr_w [2];
  logic [31:0] wdata_w [2];

  imem_loader #(.BASE_ADDR(16'h0000), .MAX_WORDS(4)) u_dut0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .byte_valid(bv_v[0]), .byte_data(bd),
    .byte_ready(rdy_w[0]), .we(we_w[0]), .waddr(waddr_w[0]), .wdata(wdata_w[0]),
    .cpu_hold(hold_w[0]), .done(done_w[0]), .err(err_w[0])
  );

  imem_loader #(.BASE_ADDR(16'hFFFC), .MAX_WORDS(1024)) u_dut1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .byte_valid(bv_v[1]), .byte_data(bd),
    .byte_ready(rdy_w[1]), .we(we_w[1]), .waddr(waddr_w[1]), .wdata(wdata_w[1]),
    .cpu_hold(hold_w[1]), .done(done_w[1]), .err(err_w[1])
  );

  always #5 clk = ~clk;

  logic [47:0] exp_q [$];
  logic [31:0] prog [4] = '{32'hFFC4A303, 32'h0064A423, 32'h12345678, 32'hDEADBEEF};
  int n_checks = 0;
  int n_errs   = 0;
  int we_cnt   = 0;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        if (we_w[k]) begin
          logic [47:0] e;
          we_cnt++;
          check("ready_in_write", {47'd0, rdy_w[k]}, 48'd0);
          if (exp_q.size() == 0) begin
            check("unexpected_we", 48'd1, 48'd0);
          end else begin
            e = exp_q.pop_front();
            check("waddr", {32'd0, waddr_w[k]}, {32'd0, e[47:32]});
            check("wdata", {16'd0, wdata_w[k]}, {16'd0, e[31:0]});
          end
        end
      end
    end
  end

  task automatic pulse_start(input int k);
    start_v[k] = 1'b1;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
  endtask

  task automatic send_byte(input int k, input logic [7:0] b, input int gap);
    int t = 0;
    bd = b;
    bv_v[k] = 1'b1;
    while (!rdy_w[k] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("ready_timeout", 48'd0, 48'd1);
    @(posedge clk); #1;
    bv_v[k] = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_words(input int k, input logic [15:0] base, input int n, input int gap);
    logic [15:0] cnt = 16'(n);
    send_byte(k, cnt[7:0], gap);
    send_byte(k, cnt[15:8], gap);
    for (int i = 0; i < n; i++) begin
      logic [31:0] w = prog[i];
      logic [15:0] a = base + 16'(4 * i);
      for (int j = 0; j < 4; j++) begin
        // The expected write is queued with the last byte so an aborted word leaves no entry.
        if (j == 3) begin
          bd = w[31:24];
          bv_v[k] = 1'b1;
          exp_q.push_back({a, w});
          send_byte(k, w[31:24], 0);
        end else begin
          send_byte(k, w[8*j +: 8], gap);
        end
      end
    end
  endtask

  task automatic expect_finish(input int k, input int n_we);
    check("we_after_last", {47'd0, we_w[k]}, 48'd1);
    @(posedge clk); #1;
    check("done_after_load", {47'd0, done_w[k]}, 48'd1);
    check("hold_after_load", {47'd0, hold_w[k]}, 48'd0);
    check("err_after_load", {47'd0, err_w[k]}, 48'd0);
    repeat (2) @(negedge clk);
    check("we_pulses", 48'(we_cnt), 48'(n_we));
    check("sb_empty", 48'(exp_q.size()), 48'd0);
  endtask

  task automatic check_reset_vals(input int k, input logic [15:0] base);
    check("rst_ready", {47'd0, rdy_w[k]}, 48'd0);
    check("rst_we", {47'd0, we_w[k]}, 48'd0);
    check("rst_waddr", {32'd0, waddr_w[k]}, {32'd0, base});
    check("rst_wdata", {16'd0, wdata_w[k]}, 48'd0);
    check("rst_hold", {47'd0, hold_w[k]}, 48'd1);
    check("rst_done", {47'd0, done_w[k]}, 48'd0);
    check("rst_err", {47'd0, err_w[k]}, 48'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start_v = '0; bv_v = '0; bd = '0;
    #1;
    check_reset_vals(0, 16'h0000);
    check_reset_vals(1, 16'hFFFC);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Basic two-word load.
    we_cnt = 0;
    pulse_start(0);
    send_words(0, 16'h0000, 2, 0);
    expect_finish(0, 2);

    // Zero count: straight to DONE, no writes.
    we_cnt = 0;
    pulse_start(0);
    send_byte(0, 8'h00, 0);
    send_byte(0, 8'h00, 0);
    check("zero_done", {47'd0, done_w[0]}, 48'd1);
    check("zero_err", {47'd0, err_w[0]}, 48'd0);
    check("zero_hold", {47'd0, hold_w[0]}, 48'd0);
    repeat (3) @(negedge clk);
    check("zero_we", 48'(we_cnt), 48'd0);

    // Count above the limit of 4.
    pulse_start(0);
    check("restart_done_clr", {47'd0, done_w[0]}, 48'd0);
    send_byte(0, 8'h05, 0);
    send_byte(0, 8'h00, 0);
    check("ovf_done", {47'd0, done_w[0]}, 48'd1);
    check("ovf_err", {47'd0, err_w[0]}, 48'd1);
    check("ovf_hold", {47'd0, hold_w[0]}, 48'd1);
    bv_v[0] = 1'b1;
    repeat (3) @(negedge clk);
    bv_v[0] = 1'b0;
    check("ovf_ready", {47'd0, rdy_w[0]}, 48'd0);
    check("ovf_we", 48'(we_cnt), 48'd0);

    // Same basic stream with 3-cycle gaps between bytes.
    we_cnt = 0;
    pulse_start(0);
    check("stall_err_clr", {47'd0, err_w[0]}, 48'd0);
    send_words(0, 16'h0000, 2, 3);
    expect_finish(0, 2);

    // Reset partway through the first word of a 4-word load.
    we_cnt = 0;
    pulse_start(0);
    send_byte(0, 8'h04, 0);
    send_byte(0, 8'h00, 0);
    send_byte(0, prog[0][7:0], 0);
    send_byte(0, prog[0][15:8], 0);
    #2 reset = 1'b1;
    #1;
    check_reset_vals(0, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    pulse_start(0);
    send_words(0, 16'h0000, 4, 1);
    expect_finish(0, 4);

    // Address wrap and reload from DONE.
    we_cnt = 0;
    pulse_start(1);
    send_words(1, 16'hFFFC, 2, 0);
    expect_finish(1, 2);
    pulse_start(1);
    check("reload_done", {47'd0, done_w[1]}, 48'd0);
    check("reload_hold", {47'd0, hold_w[1]}, 48'd1);
    check("reload_waddr", {32'd0, waddr_w[1]}, 48'h0000_0000_FFFC);
    check("reload_wdata", {16'd0, wdata_w[1]}, {16'd0, prog[1]});
    send_words(1, 16'hFFFC, 2, 0);
    expect_finish(1, 4);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
